// File: rtl/k052109_timing_pkg.sv
// Shared constants for the K052109-style timing generator: default raster
// geometry, interrupt enable bit positions and the 8-step CPU clock phase decode.
package k052109_timing_pkg;

    localparam int DEF_H_BITS = 9;
    localparam int DEF_V_BITS = 9;

    localparam logic [8:0] DEF_H_START    = 9'h020;
    localparam logic [8:0] DEF_H_END      = 9'h1FF;
    localparam logic [8:0] DEF_HVIS_START = 9'h080;
    localparam logic [8:0] DEF_V_START    = 9'h0F8;
    localparam logic [8:0] DEF_V_END      = 9'h1FF;
    localparam logic [8:0] DEF_VBLK_OFF   = 9'h110;
    localparam logic [8:0] DEF_VBLK_ON    = 9'h1F0;
    localparam logic [8:0] DEF_FIRQ_LINE  = 9'h100;

    localparam int DEF_NMI_LINES  = 32;
    localparam int DEF_RST_FRAMES = 8;

    // Bit positions inside INT_EN and the internal flag vector.
    localparam int INT_IRQ  = 0;
    localparam int INT_FIRQ = 1;
    localparam int INT_NMI  = 2;

    localparam logic [2:0] PH_RESET = 3'd0;
    localparam logic [1:0] PH_PIX   = 2'b11;

    typedef struct packed {
        logic m12;
        logic pe;
        logic pq;
        logic pix_ce;
    } phase_out_t;

    // E/Q quadrature: Q is high over phases 2..5, E over phases 4..7.
    function automatic phase_out_t phase_decode(input logic [2:0] ph);
        phase_out_t o;
        o.m12    = ph[0];
        o.pe     = ph[2];
        o.pq     = ph[2] ^ ph[1];
        o.pix_ce = (ph[1:0] == PH_PIX);
        return o;
    endfunction

endpackage

// File: rtl/k052109_wrap_counter.sv
// Enabled up-counter that reloads START after reaching END; wrap_o flags the
// enabled cycle in which the reload happens.
module k052109_wrap_counter #(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] START = '0,
    parameter logic [WIDTH-1:0] END   = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    output logic [WIDTH-1:0] q_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign wrap_o = ce_i && (q_q == END);

    always_comb begin
        q_d = q_q;
        if (ce_i) begin
            q_d = (q_q == END) ? START : q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= START;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/k052109_timing_gen.sv
// Video timing and 6809 clock generator: quadrature CPU clocks, pixel enable,
// H/V raster counters with flip, blanking, maskable interrupts and delayed CPU reset.
module k052109_timing_gen
    import k052109_timing_pkg::*;
#(
    parameter int                H_BITS     = DEF_H_BITS,
    parameter int                V_BITS     = DEF_V_BITS,
    parameter logic [H_BITS-1:0] H_START    = DEF_H_START,
    parameter logic [H_BITS-1:0] H_END      = DEF_H_END,
    parameter logic [H_BITS-1:0] HVIS_START = DEF_HVIS_START,
    parameter logic [V_BITS-1:0] V_START    = DEF_V_START,
    parameter logic [V_BITS-1:0] V_END      = DEF_V_END,
    parameter logic [V_BITS-1:0] VBLK_OFF   = DEF_VBLK_OFF,
    parameter logic [V_BITS-1:0] VBLK_ON    = DEF_VBLK_ON,
    parameter logic [V_BITS-1:0] FIRQ_LINE  = DEF_FIRQ_LINE,
    parameter int                NMI_LINES  = DEF_NMI_LINES,
    parameter int                RST_FRAMES = DEF_RST_FRAMES
) (
    input  logic              M24,
    input  logic              RES,
    input  logic              FLIP,
    input  logic [2:0]        INT_EN,
    output logic              M12,
    output logic              PE,
    output logic              PQ,
    output logic              PIX_CE,
    output logic [H_BITS-1:0] H,
    output logic [V_BITS-1:0] V,
    output logic              HBLK,
    output logic              VBLK,
    output logic              LINE_END,
    output logic              NIRQ,
    output logic              NFIRQ,
    output logic              NNMI,
    output logic              RST
);

    localparam int NMI_W = (NMI_LINES > 1) ? $clog2(NMI_LINES) : 1;
    localparam int FR_W  = $clog2(RST_FRAMES + 1);
    localparam logic [NMI_W-1:0] NMI_LAST = NMI_W'(NMI_LINES - 1);
    localparam logic [FR_W-1:0]  FR_FULL  = FR_W'(RST_FRAMES);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(RST_FRAMES - 1);

    // Reset assertion is immediate; release is delayed two M24 edges.
    logic [1:0] rst_sync_q;
    logic       rstn_s;

    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rstn_s = rst_sync_q[1];

    logic [2:0] ph_q;
    logic [2:0] ph_d;
    phase_out_t po_q;
    phase_out_t po_d;

    assign ph_d = ph_q + 3'd1;
    // Decode the upcoming phase so every clock output comes straight off a flop.
    assign po_d = phase_decode(ph_d);

    always_ff @(posedge M24 or negedge rstn_s) begin
        if (!rstn_s) begin
            ph_q <= PH_RESET;
            po_q <= '0;
        end else begin
            ph_q <= ph_d;
            po_q <= po_d;
        end
    end

    logic [H_BITS-1:0] h_raw;
    logic [V_BITS-1:0] v_raw;
    logic              line_end;
    logic              v_wrap;

    k052109_wrap_counter #(
        .WIDTH (H_BITS),
        .START (H_START),
        .END   (H_END)
    ) u_h_cnt (
        .clk_i  (M24),
        .rst_ni (rstn_s),
        .ce_i   (po_q.pix_ce),
        .q_o    (h_raw),
        .wrap_o (line_end)
    );

    k052109_wrap_counter #(
        .WIDTH (V_BITS),
        .START (V_START),
        .END   (V_END)
    ) u_v_cnt (
        .clk_i  (M24),
        .rst_ni (rstn_s),
        .ce_i   (line_end),
        .q_o    (v_raw),
        .wrap_o (v_wrap)
    );

    logic [V_BITS-1:0] v_next;
    logic              irq_t;
    logic              firq_t;
    logic              nmi_t;

    assign v_next = v_wrap ? V_START : v_raw + V_BITS'(1);
    assign irq_t  = line_end && (v_next == VBLK_ON);
    assign firq_t = line_end && (v_next == FIRQ_LINE);

    logic [NMI_W-1:0] lc_q;
    logic [NMI_W-1:0] lc_d;

    assign nmi_t = line_end && (lc_q == NMI_LAST);

    always_comb begin
        lc_d = lc_q;
        if (line_end) begin
            lc_d = (lc_q == NMI_LAST) ? '0 : lc_q + NMI_W'(1);
        end
    end

    logic [2:0] trig;
    logic [2:0] flag_q;
    logic [2:0] flag_d;

    always_comb begin
        trig           = 3'b000;
        trig[INT_IRQ]  = irq_t;
        trig[INT_FIRQ] = firq_t;
        trig[INT_NMI]  = nmi_t;
    end

    // A low enable bit wins over a trigger landing in the same cycle.
    assign flag_d = INT_EN & (flag_q | trig);

    logic [FR_W-1:0] frame_q;
    logic [FR_W-1:0] frame_d;
    logic            rst_q;
    logic            rst_d;

    always_comb begin
        frame_d = frame_q;
        rst_d   = rst_q;
        if (irq_t) begin
            if (frame_q != FR_FULL) begin
                frame_d = frame_q + FR_W'(1);
            end
            if (frame_q == FR_LAST) begin
                rst_d = 1'b1;
            end
        end
    end

    always_ff @(posedge M24 or negedge rstn_s) begin
        if (!rstn_s) begin
            lc_q    <= '0;
            flag_q  <= 3'b000;
            frame_q <= '0;
            rst_q   <= 1'b0;
        end else begin
            lc_q    <= lc_d;
            flag_q  <= flag_d;
            frame_q <= frame_d;
            rst_q   <= rst_d;
        end
    end

    assign M12      = po_q.m12;
    assign PE       = po_q.pe;
    assign PQ       = po_q.pq;
    assign PIX_CE   = po_q.pix_ce;
    assign LINE_END = line_end;

    // Blanking follows the raw raster position; flip only mirrors the reported counts.
    assign H    = h_raw ^ {H_BITS{FLIP}};
    assign V    = v_raw ^ {V_BITS{FLIP}};
    assign HBLK = (h_raw < HVIS_START);
    assign VBLK = (v_raw < VBLK_OFF) || (v_raw >= VBLK_ON);

    assign NIRQ  = ~flag_q[INT_IRQ];
    assign NFIRQ = ~flag_q[INT_FIRQ];
    assign NNMI  = ~flag_q[INT_NMI];
    assign RST   = rst_q;

endmodule

// File: tb/tb_k052109_timing_gen.sv
// Bench for k052109_timing_gen: a compact-raster instance checked against an
// arithmetic raster model, plus a default-geometry instance for line-wrap points.
module tb_k052109_timing_gen;

    localparam int HS   = 32'h020;
    localparam int HE   = 32'h02F;
    localparam int HVS  = 32'h024;
    localparam int VS   = 32'h0F8;
    localparam int VE   = 32'h10F;
    localparam int VOFF = 32'h0FA;
    localparam int VON  = 32'h10C;
    localparam int FQ   = 32'h100;
    localparam int NL   = 3;
    localparam int RF   = 8;
    localparam int HLEN = HE - HS + 1;
    localparam int VLEN = VE - VS + 1;

    logic       M24 = 1'b0;
    logic       RES = 1'b0;
    logic       FLIP = 1'b0;
    logic [2:0] INT_EN = 3'b000;

    logic       M12, PE, PQ, PIX_CE, HBLK, VBLK, LINE_END, NIRQ, NFIRQ, NNMI, RST;
    logic [8:0] H, V;
    logic       d_M12, d_PE, d_PQ, d_PIX_CE, d_HBLK, d_VBLK, d_LINE_END;
    logic       d_NIRQ, d_NFIRQ, d_NNMI, d_RST;
    logic [8:0] d_H, d_V;

    int checks = 0;
    int passed = 0;

    // Reference model state: sync stage count, cycles since release, event totals.
    int rs = 0;
    int t = 0;
    int irq_total = 0;
    int lines = 0;
    bit f_irq = 1'b0;
    bit f_firq = 1'b0;
    bit f_nmi = 1'b0;

    k052109_timing_gen #(
        .H_START    (9'h020),
        .H_END      (9'h02F),
        .HVIS_START (9'h024),
        .V_START    (9'h0F8),
        .V_END      (9'h10F),
        .VBLK_OFF   (9'h0FA),
        .VBLK_ON    (9'h10C),
        .FIRQ_LINE  (9'h100),
        .NMI_LINES  (NL),
        .RST_FRAMES (RF)
    ) dut (
        .M24(M24), .RES(RES), .FLIP(FLIP), .INT_EN(INT_EN),
        .M12(M12), .PE(PE), .PQ(PQ), .PIX_CE(PIX_CE), .H(H), .V(V),
        .HBLK(HBLK), .VBLK(VBLK), .LINE_END(LINE_END),
        .NIRQ(NIRQ), .NFIRQ(NFIRQ), .NNMI(NNMI), .RST(RST)
    );

    k052109_timing_gen dut_def (
        .M24(M24), .RES(RES), .FLIP(FLIP), .INT_EN(INT_EN),
        .M12(d_M12), .PE(d_PE), .PQ(d_PQ), .PIX_CE(d_PIX_CE), .H(d_H), .V(d_V),
        .HBLK(d_HBLK), .VBLK(d_VBLK), .LINE_END(d_LINE_END),
        .NIRQ(d_NIRQ), .NFIRQ(d_NFIRQ), .NNMI(d_NNMI), .RST(d_RST)
    );

    always #5 M24 = ~M24;

    function automatic void model_reset();
        rs = 0; t = 0; irq_total = 0; lines = 0;
        f_irq = 1'b0; f_firq = 1'b0; f_nmi = 1'b0;
    endfunction

    function automatic void model_edge();
        int p, h, ln, v, nv;
        bit le, it, ft, nt;
        if (!RES) begin
            model_reset();
        end else if (rs < 2) begin
            rs++;
        end else begin
            p  = t / 4;
            h  = HS + p % HLEN;
            ln = p / HLEN;
            v  = VS + ln % VLEN;
            le = (t % 4 == 3) && (h == HE);
            nv = (v == VE) ? VS : v + 1;
            it = le && (nv == VON);
            ft = le && (nv == FQ);
            nt = le && ((ln + 1) % NL == 0);
            f_irq  = INT_EN[0] && (f_irq || it);
            f_firq = INT_EN[1] && (f_firq || ft);
            f_nmi  = INT_EN[2] && (f_nmi || nt);
            if (it) irq_total++;
            if (le) lines++;
            t++;
        end
    endfunction

    function automatic logic [28:0] exp_vec();
        int ph, p, h, v;
        logic [8:0] fm, h9, v9;
        logic [2:0] phb;
        ph  = t % 8;
        phb = 3'(ph);
        p   = t / 4;
        h   = HS + p % HLEN;
        v   = VS + (p / HLEN) % VLEN;
        fm  = FLIP ? 9'h1FF : 9'h000;
        h9  = 9'(h) ^ fm;
        v9  = 9'(v) ^ fm;
        return {phb[0], phb[2], phb[2] ^ phb[1], phb[1:0] == 2'b11, h9, v9,
                h < HVS, (v < VOFF) || (v >= VON), (phb[1:0] == 2'b11) && (h == HE),
                ~f_irq, ~f_firq, ~f_nmi, irq_total >= RF};
    endfunction

    function automatic logic [28:0] dut_vec();
        return {M12, PE, PQ, PIX_CE, H, V, HBLK, VBLK, LINE_END, NIRQ, NFIRQ, NNMI, RST};
    endfunction

    task automatic tick();
        @(posedge M24);
        model_edge();
        @(negedge M24);
    endtask

    task automatic do_reset();
        @(negedge M24);
        RES = 1'b0;
        model_reset();
        tick();
        RES = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RES = 1'b0;
        model_reset();
        repeat (3) tick();
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL reset_vec got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
        checks++;
        if ({M12, PE, PQ, PIX_CE, LINE_END, H, V, RST, NIRQ, NFIRQ, NNMI} !== {5'b0, 9'h020, 9'h0F8, 4'b0111})
            $display("FAIL reset_const got H=%h V=%h RST=%b want H=020 V=0f8 RST=0", H, V, RST);
        else passed++;
        checks++;
        if ({d_M12, d_PE, d_PQ, d_PIX_CE, d_LINE_END, d_H, d_V, d_RST, d_NIRQ, d_NFIRQ, d_NNMI}
            !== {5'b0, 9'h020, 9'h0F8, 4'b0111})
            $display("FAIL reset_default got H=%h V=%h RST=%b want H=020 V=0f8 RST=0", d_H, d_V, d_RST);
        else passed++;
        RES = 1'b1;
        tick();
        tick();
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL release_vec got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_phase();
        logic [28:0] e;
        for (int i = 0; i < 16; i++) begin
            tick();
            e = exp_vec();
            checks++;
            if ({M12, PE, PQ, PIX_CE} !== e[28:25])
                $display("FAIL phase t=%0d got=%b exp=%b", t, {M12, PE, PQ, PIX_CE}, e[28:25]);
            else passed++;
            checks++;
            if ({d_M12, d_PE, d_PQ, d_PIX_CE} !== e[28:25])
                $display("FAIL phase_default t=%0d got=%b exp=%b", t, {d_M12, d_PE, d_PQ, d_PIX_CE}, e[28:25]);
            else passed++;
        end
    endtask

    task automatic test_line_wrap();
        int guard = 0;
        while (t < 1921 && guard < 3000) begin
            tick();
            guard++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL raster t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
            else passed++;
            if (t == 383 || t == 384) begin
                checks++;
                if ({d_H, d_HBLK} !== ((t == 383) ? {9'h07F, 1'b1} : {9'h080, 1'b0}))
                    $display("FAIL hblk_edge t=%0d got H=%h HBLK=%b", t, d_H, d_HBLK);
                else passed++;
            end
            if (t == 1919 || t == 1920) begin
                checks++;
                if ({d_H, d_LINE_END, d_V, d_VBLK}
                    !== ((t == 1919) ? {9'h1FF, 1'b1, 9'h0F8, 1'b1} : {9'h020, 1'b0, 9'h0F9, 1'b1}))
                    $display("FAIL h_wrap t=%0d got H=%h LE=%b V=%h VBLK=%b", t, d_H, d_LINE_END, d_V, d_VBLK);
                else passed++;
            end
        end
        checks++;
        if (t < 1921) $display("FAIL line_wrap_timeout t=%0d want 1921", t);
        else passed++;
    endtask

    task automatic test_irq();
        int start, guard;
        INT_EN = 3'b001;
        start = irq_total;
        guard = 0;
        while (irq_total == start && guard < 4000) begin
            tick();
            guard++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL irq_run t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if ({NIRQ, VBLK, V} !== {1'b0, 1'b1, 9'h10C})
            $display("FAIL irq_assert got NIRQ=%b VBLK=%b V=%h want 0 1 10c", NIRQ, VBLK, V);
        else passed++;
        INT_EN = 3'b000;
        tick();
        checks++;
        if (NIRQ !== 1'b1) $display("FAIL irq_clear got NIRQ=%b want 1", NIRQ);
        else passed++;
        start = irq_total;
        guard = 0;
        while (irq_total == start && guard < 4000) begin
            tick();
            guard++;
        end
        tick();
        checks++;
        if ({NIRQ, irq_total} !== {1'b1, 32'(start + 1)})
            $display("FAIL irq_masked got NIRQ=%b events=%0d want NIRQ=1", NIRQ, irq_total - start);
        else passed++;
    endtask

    task automatic test_nmi();
        int guard;
        do_reset();
        INT_EN = 3'b100;
        for (int target = 2; target <= 6; target++) begin
            guard = 0;
            while (lines < target && guard < 1000) begin
                tick();
                guard++;
                checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL nmi_run t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
                else passed++;
            end
            checks++;
            if (NNMI !== ((target == 3 || target == 6) ? 1'b0 : 1'b1))
                $display("FAIL nmi_line line=%0d got NNMI=%b", target, NNMI);
            else passed++;
            if (target == 3) begin
                INT_EN = 3'b000;
                tick();
                checks++;
                if (NNMI !== 1'b1) $display("FAIL nmi_clear got NNMI=%b want 1", NNMI);
                else passed++;
                INT_EN = 3'b100;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) INT_EN = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 127) == 0) FLIP = ~FLIP;
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL random t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
            else passed++;
        end
        FLIP = 1'b0;
    endtask

    task automatic test_rst_frames();
        int guard = 0;
        do_reset();
        INT_EN = 3'($urandom_range(0, 7));
        while (irq_total < RF + 1 && guard < 16000) begin
            tick();
            guard++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rst_run t=%0d got=%h exp=%h", t, dut_vec(), exp_vec());
            else passed++;
            if (LINE_END === 1'b1 && (irq_total == RF - 1 || irq_total == RF)) begin
                checks++;
                if (RST !== ((irq_total >= RF) ? 1'b1 : 1'b0))
                    $display("FAIL rst_level events=%0d got RST=%b", irq_total, RST);
                else passed++;
            end
        end
        checks++;
        if (irq_total < RF + 1) $display("FAIL rst_timeout events=%0d want %0d", irq_total, RF + 1);
        else passed++;
    endtask

    task automatic test_mid_reset_and_flip();
        repeat (777) tick();
        checks++;
        if (RST !== 1'b1) $display("FAIL rst_held got RST=%b want 1", RST);
        else passed++;
        #2;
        RES = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({RST, H, V, NIRQ, NFIRQ, NNMI} !== {1'b0, 9'h020, 9'h0F8, 3'b111})
            $display("FAIL mid_reset got RST=%b H=%h V=%h want 0 020 0f8", RST, H, V);
        else passed++;
        checks++;
        if ({d_RST, d_H, d_V} !== {1'b0, 9'h020, 9'h0F8})
            $display("FAIL mid_reset_default got RST=%b H=%h V=%h", d_RST, d_H, d_V);
        else passed++;
        FLIP = 1'b1;
        #1;
        checks++;
        if ({H, V, HBLK, VBLK} !== {9'h1DF, 9'h107, 1'b1, 1'b1})
            $display("FAIL flip got H=%h V=%h HBLK=%b want 1df 107 1", H, V, HBLK);
        else passed++;
        checks++;
        if ({d_H, d_HBLK} !== {9'h1DF, 1'b1}) $display("FAIL flip_default got H=%h HBLK=%b", d_H, d_HBLK);
        else passed++;
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL flip_vec got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
        FLIP = 1'b0;
        @(negedge M24);
        RES = 1'b1;
        repeat (40) tick();
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL post_reset got=%h exp=%h", dut_vec(), exp_vec());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_phase();
        test_line_wrap();
        test_irq();
        test_nmi();
        test_random();
        test_rst_frames();
        test_mid_reset_and_flip();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
